// File: rtl/sc_fibonacci_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_fibonacci_sequencer_pkg
// Description : Shared definitions for the Fibonacci micro-sequencer.
//               FSM state and transfer-phase encodings, decoder/mux/ALU/
//               shifter control codes, and the helpers that map
//               (state, transfer index, phase) to a control word.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_fibonacci_sequencer_pkg;

    // Native control-field widths. The top-level parameters default to these.
    localparam int c_DDS_W = 3;
    localparam int c_DMS_W = 3;
    localparam int c_DAS_W = 4;
    localparam int c_DRS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_CHK  = 3'd2,
        ST_LOOP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_X0 = 2'd0,
        PH_X1 = 2'd1,
        PH_X2 = 2'd2
    } phase_t;

    // Decoder codes
    localparam logic [c_DDS_W-1:0] c_DEC_GEN0 = 3'b000;
    localparam logic [c_DDS_W-1:0] c_DEC_GEN1 = 3'b001;
    localparam logic [c_DDS_W-1:0] c_DEC_GEN2 = 3'b010;
    localparam logic [c_DDS_W-1:0] c_DEC_NONE = 3'b111;

    // BUSA/BUSB mux codes
    localparam logic [c_DMS_W-1:0] c_MUX_GEN0 = 3'b000;
    localparam logic [c_DMS_W-1:0] c_MUX_GEN1 = 3'b001;
    localparam logic [c_DMS_W-1:0] c_MUX_GEN2 = 3'b010;
    localparam logic [c_DMS_W-1:0] c_MUX_FIX0 = 3'b100;
    localparam logic [c_DMS_W-1:0] c_MUX_FIX1 = 3'b101;
    localparam logic [c_DMS_W-1:0] c_MUX_IDLE = 3'b111;

    // ALU opcodes
    localparam logic [c_DAS_W-1:0] c_ALU_PASS = 4'b0000;
    localparam logic [c_DAS_W-1:0] c_ALU_ADD  = 4'b1000;
    localparam logic [c_DAS_W-1:0] c_ALU_IDLE = 4'b1111;

    // Shifter: mode 11 leaves the loaded value unshifted
    localparam logic [c_DRS_W-1:0] c_SHF_NOP  = 2'b11;

    // Transfer index of the ADD inside a LOOP iteration (the carry-checked one)
    localparam logic [1:0] c_XFER_ADD = 2'd0;

    // One register transfer Rd <- op(A, B)
    typedef struct packed {
        logic [c_DDS_W-1:0] rd;
        logic [c_DMS_W-1:0] mux_a;
        logic [c_DMS_W-1:0] mux_b;
        logic [c_DAS_W-1:0] alu;
    } xfer_t;

    // Registered control word presented on the outputs
    typedef struct packed {
        logic [c_DDS_W-1:0] dec_load;
        logic [c_DMS_W-1:0] mux_a;
        logic [c_DMS_W-1:0] mux_b;
        logic [c_DAS_W-1:0] alu;
        logic               shf_load_n;
        logic               busy;
        logic               done;
    } ctrl_t;

    localparam ctrl_t c_CTRL_IDLE = '{
        dec_load   : c_DEC_NONE,
        mux_a      : c_MUX_IDLE,
        mux_b      : c_MUX_IDLE,
        alu        : c_ALU_IDLE,
        shf_load_n : 1'b1,
        busy       : 1'b0,
        done       : 1'b0
    };

    // Microprogram: which transfer a given state/index performs.
    function automatic xfer_t transfer_of(input state_t st, input logic [1:0] idx);
        xfer_t x;
        x = '{rd: c_DEC_NONE, mux_a: c_MUX_IDLE, mux_b: c_MUX_IDLE, alu: c_ALU_IDLE};
        if (st == ST_INIT) begin
            if (idx == 2'd0) x = '{rd: c_DEC_GEN0, mux_a: c_MUX_FIX0, mux_b: c_MUX_IDLE, alu: c_ALU_PASS};
            else             x = '{rd: c_DEC_GEN1, mux_a: c_MUX_FIX1, mux_b: c_MUX_IDLE, alu: c_ALU_PASS};
        end else if (st == ST_LOOP) begin
            case (idx)
                2'd0:    x = '{rd: c_DEC_GEN2, mux_a: c_MUX_GEN0, mux_b: c_MUX_GEN1, alu: c_ALU_ADD};
                2'd1:    x = '{rd: c_DEC_GEN0, mux_a: c_MUX_GEN1, mux_b: c_MUX_IDLE, alu: c_ALU_PASS};
                default: x = '{rd: c_DEC_GEN1, mux_a: c_MUX_GEN2, mux_b: c_MUX_IDLE, alu: c_ALU_PASS};
            endcase
        end
        return x;
    endfunction

    // Moore decode: X0 drives mux+ALU, X1 adds the shifter load, X2 loads Rd.
    function automatic ctrl_t decode_controls(input state_t st, input phase_t ph, input logic [1:0] idx);
        ctrl_t c;
        xfer_t x;
        c      = c_CTRL_IDLE;
        c.busy = (st != ST_IDLE) && (st != ST_DONE);
        c.done = (st == ST_DONE);
        if ((st == ST_INIT) || (st == ST_LOOP)) begin
            x = transfer_of(st, idx);
            case (ph)
                PH_X0: begin
                    c.mux_a = x.mux_a;
                    c.mux_b = x.mux_b;
                    c.alu   = x.alu;
                end
                PH_X1: begin
                    c.mux_a      = x.mux_a;
                    c.mux_b      = x.mux_b;
                    c.alu        = x.alu;
                    c.shf_load_n = 1'b0;
                end
                default: c.dec_load = x.rd;
            endcase
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_fibonacci_sequencer_transfer_stepper.sv
`default_nettype none
// ============================================================================
// Module      : sc_transfer_stepper
// Description : Three-phase (X0/X1/X2) timing generator for one register
//               transfer. Advances while i_advance is high and falls back
//               to X0 otherwise. o_step_done marks the X2 (write-back) cycle.
// Ports       : clk, rst (async, active high), i_advance,
//               o_phase_q (current phase), o_phase_d (next phase),
//               o_step_done
// Revision    : 1.0 - initial release
// ============================================================================
module sc_transfer_stepper
    import sc_fibonacci_sequencer_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_advance,
    output phase_t    o_phase_q,
    output phase_t    o_phase_d,
    output logic      o_step_done
);

    phase_t r_phase_q;
    phase_t w_phase_d;

    always_comb begin
        w_phase_d = PH_X0;
        if (i_advance) begin
            case (r_phase_q)
                PH_X0:   w_phase_d = PH_X1;
                PH_X1:   w_phase_d = PH_X2;
                default: w_phase_d = PH_X0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phase_q <= PH_X0;
        else     r_phase_q <= w_phase_d;
    end

    assign o_phase_q   = r_phase_q;
    assign o_phase_d   = w_phase_d;
    assign o_step_done = (r_phase_q == PH_X2);

endmodule
`default_nettype wire

// File: rtl/sc_fibonacci_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sc_fibonacci_sequencer
// Description : Start/done micro-sequencer that drives the shared register/
//               ALU/shifter datapath to compute F(N). On completion GEN0 holds
//               F(N) and GEN1 holds F(N+1) (FIX0 = 0, FIX1 = 1).
//               Build option: FIBSEQ_CARRY_ABORT_EN - abort a run on ALU
//               carry during the ADD, set error, keep the last valid pair.
// Ports       : SC_FIBSEQ_CLOCK_50, SC_FIBSEQ_RESET_InHigh (async),
//               start_InLow, count_InBUS, carry_InLow (inputs);
//               decoder clear/load, BUSA/BUSB mux, ALU, shifter clear/load/
//               shift select, busy, done, error (registered outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module sc_fibonacci_sequencer
    import sc_fibonacci_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int COUNT_WIDTH                    = 5
)(
    input  wire logic                                      SC_FIBSEQ_CLOCK_50,
    input  wire logic                                      SC_FIBSEQ_RESET_InHigh,
    input  wire logic                                      SC_FIBSEQ_start_InLow,
    input  wire logic [COUNT_WIDTH-1:0]                    SC_FIBSEQ_count_InBUS,
    input  wire logic                                      SC_FIBSEQ_carry_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]         SC_FIBSEQ_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]         SC_FIBSEQ_decoderloadselection_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]             SC_FIBSEQ_muxselectionBUSA_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]             SC_FIBSEQ_muxselectionBUSB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]             SC_FIBSEQ_aluselection_OutBUS,
    output logic                                           SC_FIBSEQ_regSHIFTERclear_OutLow,
    output logic                                           SC_FIBSEQ_regSHIFTERload_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0]      SC_FIBSEQ_regSHIFTERshiftselection_OutLow,
    output logic                                           SC_FIBSEQ_busy_OutHigh,
    output logic                                           SC_FIBSEQ_done_OutHigh,
    output logic                                           SC_FIBSEQ_error_OutHigh
);

    wire logic clk = SC_FIBSEQ_CLOCK_50;
    wire logic rst = SC_FIBSEQ_RESET_InHigh;

    state_t                 r_state_q, w_state_d;
    logic [COUNT_WIDTH-1:0] r_count_q, w_count_d;
    logic [1:0]             r_xfer_q,  w_xfer_d;
    logic                   r_error_q, w_error_d;
    ctrl_t                  r_ctrl_q,  w_ctrl_d;

    logic   w_advance;
    phase_t w_phase_q;
    phase_t w_phase_d;
    logic   w_step_done;
    logic   w_carry_abort;

    sc_transfer_stepper u_stepper (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_advance),
        .o_phase_q   (w_phase_q),
        .o_phase_d   (w_phase_d),
        .o_step_done (w_step_done)
    );

`ifdef FIBSEQ_CARRY_ABORT_EN
    // Carry is only meaningful while the ADD is on the buses with the
    // shifter capturing it; that is the X1 cycle of the first LOOP transfer.
    assign w_carry_abort = (r_state_q == ST_LOOP) && (r_xfer_q == c_XFER_ADD) &&
                           (w_phase_q == PH_X1) && !SC_FIBSEQ_carry_InLow;
`else
    logic w_carry_unused;
    assign w_carry_unused = SC_FIBSEQ_carry_InLow;
    assign w_carry_abort  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        w_xfer_d  = r_xfer_q;
        w_error_d = r_error_q;
        w_advance = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (!SC_FIBSEQ_start_InLow) begin
                    w_state_d = ST_INIT;
                    w_count_d = SC_FIBSEQ_count_InBUS;
                    w_xfer_d  = 2'd0;
                    w_error_d = 1'b0;
                end
            end
            ST_INIT: begin
                w_advance = 1'b1;
                if (w_step_done) begin
                    if (r_xfer_q == 2'd1) begin
                        w_state_d = ST_CHK;
                        w_xfer_d  = 2'd0;
                    end else begin
                        w_xfer_d  = r_xfer_q + 2'd1;
                    end
                end
            end
            ST_CHK: begin
                // Zero test happens before any decrement, so no underflow.
                w_xfer_d  = 2'd0;
                w_state_d = (r_count_q == '0) ? ST_DONE : ST_LOOP;
            end
            ST_LOOP: begin
                if (w_carry_abort) begin
                    // GEN2 write-back is skipped: GEN0/GEN1 keep the last valid pair.
                    w_state_d = ST_DONE;
                    w_error_d = 1'b1;
                    w_xfer_d  = 2'd0;
                end else begin
                    w_advance = 1'b1;
                    if (w_step_done) begin
                        if (r_xfer_q == 2'd2) begin
                            w_state_d = ST_CHK;
                            w_xfer_d  = 2'd0;
                            w_count_d = r_count_q - COUNT_WIDTH'(1);
                        end else begin
                            w_xfer_d  = r_xfer_q + 2'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (SC_FIBSEQ_start_InLow) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Controls are decoded from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        w_ctrl_d = decode_controls(w_state_d, w_phase_d, w_xfer_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_count_q <= '0;
            r_xfer_q  <= 2'd0;
            r_error_q <= 1'b0;
            r_ctrl_q  <= c_CTRL_IDLE;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
            r_xfer_q  <= w_xfer_d;
            r_error_q <= w_error_d;
            r_ctrl_q  <= w_ctrl_d;
        end
    end

    assign SC_FIBSEQ_decoderclearselection_OutBUS    = DATAWIDTH_DECODER_SELECTION'(c_DEC_NONE);
    assign SC_FIBSEQ_decoderloadselection_OutBUS     = DATAWIDTH_DECODER_SELECTION'(r_ctrl_q.dec_load);
    assign SC_FIBSEQ_muxselectionBUSA_OutBUS         = DATAWIDTH_MUX_SELECTION'(r_ctrl_q.mux_a);
    assign SC_FIBSEQ_muxselectionBUSB_OutBUS         = DATAWIDTH_MUX_SELECTION'(r_ctrl_q.mux_b);
    assign SC_FIBSEQ_aluselection_OutBUS             = DATAWIDTH_ALU_SELECTION'(r_ctrl_q.alu);
    assign SC_FIBSEQ_regSHIFTERclear_OutLow          = 1'b1;
    assign SC_FIBSEQ_regSHIFTERload_OutLow           = r_ctrl_q.shf_load_n;
    assign SC_FIBSEQ_regSHIFTERshiftselection_OutLow = DATAWIDTH_REGSHIFTER_SELECTION'(c_SHF_NOP);
    assign SC_FIBSEQ_busy_OutHigh                    = r_ctrl_q.busy;
    assign SC_FIBSEQ_done_OutHigh                    = r_ctrl_q.done;
    assign SC_FIBSEQ_error_OutHigh                   = r_error_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_fibonacci_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_fibonacci_sequencer
// Description : Self-checking bench for sc_fibonacci_sequencer with an 8-bit
//               register/ALU/shifter datapath attached. Expected results come
//               from a plain Fibonacci reference and are queued at start; a
//               monitor pops and compares on each done assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_fibonacci_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_n;
    logic [4:0] count;
    logic       carry_n;
    logic [2:0] dec_clr, dec_load, mux_a, mux_b;
    logic [3:0] alu_sel;
    logic       shf_clr, shf_load_n;
    logic [1:0] shf_sel;
    logic       busy, done, err;

    always #5 clk = ~clk;

    sc_fibonacci_sequencer dut (
        .SC_FIBSEQ_CLOCK_50                        (clk),
        .SC_FIBSEQ_RESET_InHigh                    (rst),
        .SC_FIBSEQ_start_InLow                     (start_n),
        .SC_FIBSEQ_count_InBUS                     (count),
        .SC_FIBSEQ_carry_InLow                     (carry_n),
        .SC_FIBSEQ_decoderclearselection_OutBUS    (dec_clr),
        .SC_FIBSEQ_decoderloadselection_OutBUS     (dec_load),
        .SC_FIBSEQ_muxselectionBUSA_OutBUS         (mux_a),
        .SC_FIBSEQ_muxselectionBUSB_OutBUS         (mux_b),
        .SC_FIBSEQ_aluselection_OutBUS             (alu_sel),
        .SC_FIBSEQ_regSHIFTERclear_OutLow          (shf_clr),
        .SC_FIBSEQ_regSHIFTERload_OutLow           (shf_load_n),
        .SC_FIBSEQ_regSHIFTERshiftselection_OutLow (shf_sel),
        .SC_FIBSEQ_busy_OutHigh                    (busy),
        .SC_FIBSEQ_done_OutHigh                    (done),
        .SC_FIBSEQ_error_OutHigh                   (err)
    );

    // ---------------- 8-bit datapath environment ----------------
    logic [7:0] gen [0:3];
    logic [7:0] sh_reg;
    logic [7:0] bus_a, bus_b, alu_res;
    logic [8:0] sum9;

    function automatic logic [7:0] bus_val(input logic [2:0] sel);
        case (sel)
            3'b000:  return gen[0];
            3'b001:  return gen[1];
            3'b010:  return gen[2];
            3'b011:  return gen[3];
            3'b101:  return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        bus_a   = bus_val(mux_a);
        bus_b   = bus_val(mux_b);
        sum9    = {1'b0, bus_a} + {1'b0, bus_b};
        alu_res = 8'd0;
        if (alu_sel == 4'b0000) alu_res = bus_a;
        else if (alu_sel == 4'b1000) alu_res = sum9[7:0];
        carry_n = !((alu_sel == 4'b1000) && sum9[8]);
    end

    always @(posedge clk) begin
        if (!shf_load_n) sh_reg <= alu_res;
        if (dec_load[2] == 1'b0) gen[dec_load[1:0]] <= sh_reg;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int g0;
        int g1;
        int er;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   busy_cnt    = 0;
    logic done_prev   = 1'b0;

    localparam logic [21:0] IDLE_WORD = 22'b111_111_111_111_1111_1_1_11_0_0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: Fibonacci by plain arithmetic, plus the run length in busy cycles
    // (6 init + 1 check, then 10 per completed iteration; an aborted ADD costs 2).
    function automatic exp_t ref_model(input int n);
        exp_t e;
        int a, b, s;
        a = 0; b = 1;
        e.er = 0; e.cyc = 7;
        for (int k = 1; k <= n; k++) begin
            s = a + b;
`ifdef FIBSEQ_CARRY_ABORT_EN
            if (s > 255) begin
                e.er = 1;
                e.cyc += 2;
                break;
            end
`endif
            a = b;
            b = s % 256;
            e.cyc += 10;
        end
        e.g0 = a; e.g1 = b;
        return e;
    endfunction

    function automatic logic [21:0] ctl_word();
        return {dec_clr, dec_load, mux_a, mux_b, alu_sel, shf_clr, shf_load_n, shf_sel, busy, done};
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gen0", 32'(gen[0]), 32'(e.g0));
                    chk("gen1", 32'(gen[1]), 32'(e.g1));
                    chk("error", 32'(err), 32'(e.er));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
                end
                busy_cnt = 0;
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n, input bit hold);
        exp_t e;
        bit   seen;
        e = ref_model(n);
        @(posedge clk); #1;
        count   = 5'(n);
        start_n = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        count = 5'($urandom);
        if (!hold) begin
            start_n = 1'b1;
            // A start request while busy must be ignored.
            repeat (3) @(posedge clk);
            #1 start_n = 1'b0;
            count = 5'($urandom);
            @(posedge clk); #1 start_n = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
            start_n = 1'b1;
            return;
        end
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_held", 32'(done), 32'd1);
            end
            @(posedge clk); #1 start_n = 1'b1;
        end
        @(negedge clk);
        @(posedge clk); #1;
        chk("idle_after_done", 32'(ctl_word()), 32'(IDLE_WORD));
        chk("error_hold", 32'(err), 32'(e.er));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) gen[i] = 8'd0;
        sh_reg  = 8'd0;
        rst     = 1'b1;
        start_n = 1'b1;
        count   = 5'd0;
        #1;
        chk("reset_ctl", 32'(ctl_word()), 32'(IDLE_WORD));
        chk("reset_error", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 1'b0);
        run(1, 1'b0);
        run(10, 1'b0);
        run(12, 1'b0);
        run(13, 1'b1);

        // Reset in the middle of a LOOP
        @(posedge clk); #1;
        count = 5'd5; start_n = 1'b0;
        @(posedge clk); #1 start_n = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_reset_ctl", 32'(ctl_word()), 32'(IDLE_WORD));
        chk("midrun_reset_error", 32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_reset_idle", 32'(ctl_word()), 32'(IDLE_WORD));

        for (int r = 0; r < 12; r++) begin
            run(int'($urandom_range(0, 16)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
